// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by the lane aligner and the top.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Byte-offset bits cleared to form a word address
    localparam logic [1:0] OFS_MASK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD_CAP,
        S_ST_WAIT,
        S_RMW_WAIT,
        S_RMW_CAP,
        S_RMW_WR,
        S_ERR
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane select for loads and lane merge for sub-word stores.
// Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      ofs,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ldata,
    output logic [XLEN-1:0] sdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{ofs, 3'b000} +: 8];
        half_v = word[{ofs[1], 4'b0000} +: 16];
        ldata  = word;
        unique case (funct3)
            F3_B:    ldata = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_BU:   ldata = {{(XLEN-8){1'b0}}, byte_v};
            F3_H:    ldata = {{(XLEN-16){half_v[15]}}, half_v};
            F3_HU:   ldata = {{(XLEN-16){1'b0}}, half_v};
            default: ldata = word;
        endcase
    end

    always_comb begin
        sdata = word;
        unique case (funct3[1:0])
            2'b00:   sdata[{ofs, 3'b000} +: 8] = wdata[7:0];
            2'b01:   sdata[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
            default: sdata = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for a word-only data memory.
// Sub-word stores are read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          state;
    logic [2:0]      f3_q;
    logic [1:0]      ofs_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] ldata;
    logic [XLEN-1:0] sdata;
    logic            misal;
    logic            illegal;
    logic            oor;
    logic            req_err;

    assign req_ready = (state == S_IDLE);

    always_comb begin
        misal = 1'b0;
        if (req_funct3[1:0] == 2'b01)
            misal = req_addr[0];
        else if (req_funct3[1:0] == 2'b10)
            misal = |req_addr[1:0];
        illegal = req_is_store ? (req_funct3 > F3_W)
                : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'd6);
        oor     = |req_addr[XLEN-1:MEM_WORDS_LOG2+2];
        req_err = misal | illegal | oor;
    end

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3 (f3_q),
        .ofs    (ofs_q),
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .ldata  (ldata),
        .sdata  (sdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            f3_q       <= '0;
            ofs_q      <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            unique case (state)
                S_IDLE: if (req_valid) begin
                    f3_q    <= req_funct3;
                    ofs_q   <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    if (req_err) begin
                        state <= S_ERR;
                    end else if (!req_is_store) begin
                        mem_read <= 1'b1;
                        mem_addr <= req_addr & ~XLEN'(OFS_MASK);
                        state    <= S_LD_WAIT;
                    end else if (req_funct3 == F3_W) begin
                        mem_write <= 1'b1;
                        mem_addr  <= req_addr & ~XLEN'(OFS_MASK);
                        mem_wdata <= req_wdata;
                        state     <= S_ST_WAIT;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= req_addr & ~XLEN'(OFS_MASK);
                        state    <= S_RMW_WAIT;
                    end
                end
                S_LD_WAIT: begin
                    mem_read <= 1'b0;
                    state    <= S_LD_CAP;
                end
                S_LD_CAP: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ldata;
                    state      <= S_IDLE;
                end
                S_ST_WAIT: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_RMW_WAIT: begin
                    mem_read <= 1'b0;
                    state    <= S_RMW_CAP;
                end
                S_RMW_CAP: begin
                    mem_write <= 1'b1;
                    mem_wdata <= sdata;
                    state     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-wide memory model.
// Expected responses are queued at issue and popped on resp_valid.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] mem [256];

    load_store_unit #(.MEM_WORDS_LOG2(8), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_read ? mem[mem_addr[9:2]] : 32'h0;
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL resp_unexpected: got rdata=%h err=%b, none queued",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (resp_rdata !== e.rd || resp_err !== e.err)
                    $display("FAIL resp: got rdata=%h err=%b, want rdata=%h err=%b",
                             resp_rdata, resp_err, e.rd, e.err);
                else
                    passed++;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < 50 && !req_ready; i++)
            @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_wdata    = 32'hA5A5_A5A5;
        req_addr     = 32'hFFFF_FFFF;
    endtask

    task automatic wait_resp(output int lat, output int nrd, output int nwr,
                             output logic [31:0] wd, output logic bad);
        lat = -1;
        nrd = 0;
        nwr = 0;
        wd  = 32'h0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read)  nrd++;
            if (mem_write) begin
                nwr++;
                wd = mem_wdata;
            end
            if (mem_read && mem_write) bad = 1'b1;
            if (resp_valid) begin
                lat = i;
                break;
            end
            if (req_ready) bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000",
                     {req_ready, resp_valid, resp_err, mem_read, mem_write});
        else passed++;
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0)
            $display("FAIL reset_data: got %h %h %h want 0",
                     resp_rdata, mem_addr, mem_wdata);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sw_preload();
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        sb_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 3'd2, 32'h10, 32'h80FF_7F01);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 1 || nrd !== 0 || nwr !== 1 || wd !== 32'h80FF_7F01 || bad)
            $display("FAIL sw_seq: got lat=%0d rd=%0d wr=%0d wd=%h bad=%b want 1 0 1 80ff7f01 0",
                     lat, nrd, nwr, wd, bad);
        else passed++;
    endtask

    task automatic test_lw();
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        sb_q.push_back('{32'h80FF_7F01, 1'b0});
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 2 || nrd !== 1 || nwr !== 0 || bad)
            $display("FAIL lw_seq: got lat=%0d rd=%0d wr=%0d bad=%b want 2 1 0 0",
                     lat, nrd, nwr, bad);
        else passed++;
    endtask

    task automatic test_sub_loads();
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exs [4] = '{32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_7F01};
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{exs[k], 1'b0});
            issue(1'b0, f3s[k], adr[k], 32'h0);
            wait_resp(lat, nrd, nwr, wd, bad);
            checks++;
            if (lat !== 2 || nrd !== 1 || nwr !== 0 || bad)
                $display("FAIL subload_seq[%0d]: got lat=%0d rd=%0d wr=%0d want 2 1 0",
                         k, lat, nrd, nwr);
            else passed++;
        end
    endtask

    task automatic test_rmw();
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        sb_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 3'd0, 32'h11, 32'h1234_56AA);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || wd !== 32'h80FF_AA01 || bad)
            $display("FAIL sb_seq: got lat=%0d rd=%0d wr=%0d wd=%h want 3 1 1 80ffaa01",
                     lat, nrd, nwr, wd);
        else passed++;
        sb_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 3'd1, 32'h12, 32'h0000_BEEF);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || wd !== 32'hBEEF_AA01 || bad)
            $display("FAIL sh_seq: got lat=%0d rd=%0d wr=%0d wd=%h want 3 1 1 beefaa01",
                     lat, nrd, nwr, wd);
        else passed++;
        checks++;
        if (mem[4] !== 32'hBEEF_AA01)
            $display("FAIL rmw_mem: got %h want beefaa01", mem[4]);
        else passed++;
    endtask

    task automatic test_errors();
        logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
        logic [31:0] adr [4] = '{32'h12, 32'h11, 32'h10, 32'h400};
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{32'h0, 1'b1});
            issue(sts[k], f3s[k], adr[k], 32'h1111_1111);
            wait_resp(lat, nrd, nwr, wd, bad);
            checks++;
            if (lat !== 1 || nrd !== 0 || nwr !== 0 || bad)
                $display("FAIL err_seq[%0d]: got lat=%0d rd=%0d wr=%0d want 1 0 0",
                         k, lat, nrd, nwr);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, nrd, nwr;
        logic [31:0] wd;
        logic bad;
        sb_q.push_back('{32'hBEEF_AA01, 1'b0});
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (req_ready !== 1'b1 || lat !== 2)
            $display("FAIL b2b_ready: got ready=%b lat=%0d want 1 2", req_ready, lat);
        else passed++;
        sb_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 1 || nwr !== 1 || wd !== 32'hDEAD_BEEF || bad)
            $display("FAIL b2b_sw: got lat=%0d wr=%0d wd=%h want 1 1 deadbeef",
                     lat, nwr, wd);
        else passed++;
        sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        wait_resp(lat, nrd, nwr, wd, bad);
        checks++;
        if (lat !== 2 || nrd !== 1 || bad)
            $display("FAIL b2b_lw: got lat=%0d rd=%0d want 2 1", lat, nrd);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int nwr = 0;
        int nresp = 0;
        issue(1'b1, 3'd0, 32'h10, 32'h0000_0055);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000
            || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL abort_outputs: got %b addr=%h wd=%h want 1000 0 0",
                     {req_ready, resp_valid, mem_read, mem_write}, mem_addr, mem_wdata);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write) nwr++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_write) nwr++;
            if (resp_valid) nresp++;
        end
        checks++;
        if (nwr !== 0 || nresp !== 0)
            $display("FAIL abort_quiet: got writes=%0d resps=%0d want 0 0", nwr, nresp);
        else passed++;
        checks++;
        if (mem[4] !== 32'hBEEF_AA01)
            $display("FAIL abort_mem: got %h want beefaa01", mem[4]);
        else passed++;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        test_reset();
        test_sw_preload();
        test_lw();
        test_sub_loads();
        test_rmw();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0)
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
